sce_pcr_ctrl: RTL and testbench

- Drives the SCE power/clock/reset domain: produces the gated-clock enable and the synchronous domain reset consumed over the pcr interface.
- Sequences reset hold, run, sleep drain, clock gating and wake-up with a req/ack sleep handshake.
- Sits between the system-level clock/reset and all SCE logic that samples CLK/RSTN.

---
 rtl/sce_pcr_pkg.sv | 17 +
 rtl/sce_pcr_dly_cnt.sv | 28 ++
 rtl/sce_pcr_ctrl.sv | 156 +++++++++++++++
 tb/tb_sce_pcr_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sce_pcr_pkg.sv
// SCE power/clock/reset controller shared types and default timing constants.
// State encoding is visible on PSTATE, so it is fixed here.
package sce_pcr_pkg;

    localparam int PSTATE_W            = 3;
    localparam int RST_HOLD_CYC_DEF    = 16;
    localparam int CLK_SETTLE_CYC_DEF  = 4;

    typedef enum logic [PSTATE_W-1:0] {
        ST_RST_HOLD = 3'd0,
        ST_RUN      = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_GATE     = 3'd3,
        ST_UNGATE   = 3'd4
    } pcr_state_e;

endpackage

// File: rtl/sce_pcr_dly_cnt.sv
// Shared delay counter: counts while enabled, holds at the terminal value.
// Latency: tc reflects the registered count combinationally; no backpressure.
module sce_pcr_dly_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = (cnt == tc_val);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sce_pcr_ctrl.sv
// SCE power/clock/reset sequencer: reset hold, run, sleep drain, clock gate, wake.
// Moore outputs, one edge from input to output; no backpressure (req/ack sleep handshake).
// Drain watchdog and SLP_ERR are built only when SCE_PCR_WDT_EN is defined.
module sce_pcr_ctrl
    import sce_pcr_pkg::*;
#(
    parameter int RST_HOLD_CYC   = RST_HOLD_CYC_DEF,
    parameter int CLK_SETTLE_CYC = CLK_SETTLE_CYC_DEF,
    parameter int SLP_TMO_CYC    = 64,
    parameter int CNT_W          = 8
) (
    input  logic                CLK,
    input  logic                RSTN,
    input  logic                SRST_REQ,
    input  logic                SLP_REQ,
    input  logic                IDLE,
    input  logic                WAKE,
    output logic                SLP_ACK,
    output logic                SLP_ERR,
    output logic                CLK_EN,
    output logic                RSTN_O,
    output logic [PSTATE_W-1:0] PSTATE,
    output logic                BUSY
);

    localparam logic [CNT_W-1:0] HOLD_TC   = CNT_W'(RST_HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_TC = CNT_W'(CLK_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_TC    = CNT_W'(SLP_TMO_CYC - 1);

    pcr_state_e       state;
    pcr_state_e       state_nxt;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_tc;
    logic [CNT_W-1:0] cnt_tc_val;
    logic             wdt_fire;

    sce_pcr_dly_cnt #(
        .CNT_W (CNT_W)
    ) u_dly_cnt (
        .clk    (CLK),
        .rstn   (RSTN),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .tc_val (cnt_tc_val),
        .tc     (cnt_tc)
    );

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state <= ST_RST_HOLD;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wdt_fire   = 1'b0;
        cnt_en     = 1'b0;
        cnt_tc_val = HOLD_TC;
        case (state)
            ST_RST_HOLD: begin
                cnt_en = 1'b1;
                if (!SRST_REQ && cnt_tc) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (SRST_REQ) begin
                    state_nxt = ST_RST_HOLD;
                end else if (SLP_REQ) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cnt_tc_val = TMO_TC;
`ifdef SCE_PCR_WDT_EN
                cnt_en = 1'b1;
`endif
                if (SRST_REQ) begin
                    state_nxt = ST_RST_HOLD;
                end else if (!SLP_REQ) begin
                    state_nxt = ST_RUN;
                end else if (IDLE) begin
                    state_nxt = ST_GATE;
`ifdef SCE_PCR_WDT_EN
                end else if (cnt_tc) begin
                    state_nxt = ST_RUN;
                    wdt_fire  = 1'b1;
`endif
                end
            end
            ST_GATE: begin
                if (SRST_REQ) begin
                    state_nxt = ST_RST_HOLD;
                end else if (WAKE || !SLP_REQ) begin
                    state_nxt = ST_UNGATE;
                end
            end
            ST_UNGATE: begin
                cnt_tc_val = SETTLE_TC;
                cnt_en     = 1'b1;
                if (SRST_REQ) begin
                    state_nxt = ST_RST_HOLD;
                end else if (cnt_tc) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RST_HOLD;
            end
        endcase
    end

    // A soft reset inside RST_HOLD does not change state but must restart the hold.
    assign cnt_clr = (state_nxt != state) || ((state == ST_RST_HOLD) && SRST_REQ);

`ifdef SCE_PCR_WDT_EN
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            SLP_ERR <= 1'b0;
        end else begin
            SLP_ERR <= wdt_fire;
        end
    end
`else
    assign SLP_ERR = 1'b0;
`endif

    always_comb begin
        CLK_EN  = 1'b1;
        SLP_ACK = 1'b0;
        RSTN_O  = 1'b0;
        BUSY    = 1'b1;
        PSTATE  = state;
        case (state)
            ST_RUN: begin
                RSTN_O = 1'b1;
                BUSY   = 1'b0;
            end
            ST_DRAIN, ST_UNGATE: begin
                RSTN_O = 1'b1;
            end
            ST_GATE: begin
                RSTN_O  = 1'b1;
                CLK_EN  = 1'b0;
                SLP_ACK = 1'b1;
            end
            default: begin
                RSTN_O = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sce_pcr_ctrl.sv
// Directed bench for sce_pcr_ctrl with default timing (hold 16, settle 4, timeout 64).
module tb_sce_pcr_ctrl;

    logic       CLK;
    logic       RSTN;
    logic       SRST_REQ;
    logic       SLP_REQ;
    logic       IDLE;
    logic       WAKE;
    logic       SLP_ACK;
    logic       SLP_ERR;
    logic       CLK_EN;
    logic       RSTN_O;
    logic [2:0] PSTATE;
    logic       BUSY;

    int n_chk = 0;
    int n_err = 0;

    sce_pcr_ctrl #(
        .RST_HOLD_CYC   (16),
        .CLK_SETTLE_CYC (4),
        .SLP_TMO_CYC    (64),
        .CNT_W          (8)
    ) dut (
        .CLK      (CLK),
        .RSTN     (RSTN),
        .SRST_REQ (SRST_REQ),
        .SLP_REQ  (SLP_REQ),
        .IDLE     (IDLE),
        .WAKE     (WAKE),
        .SLP_ACK  (SLP_ACK),
        .SLP_ERR  (SLP_ERR),
        .CLK_EN   (CLK_EN),
        .RSTN_O   (RSTN_O),
        .PSTATE   (PSTATE),
        .BUSY     (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pstate"}, 32'(PSTATE), 32'd0);
        check({tag, "_rstn_o"}, 32'(RSTN_O), 32'd0);
        check({tag, "_clk_en"}, 32'(CLK_EN), 32'd1);
        check({tag, "_slp_ack"}, 32'(SLP_ACK), 32'd0);
        check({tag, "_busy"}, 32'(BUSY), 32'd1);
        check({tag, "_slp_err"}, 32'(SLP_ERR), 32'd0);
    endtask

    // From the current edge, 15 more edges keep RST_HOLD and the 16th enters RUN.
    task automatic expect_hold_release(input string tag);
        for (int i = 1; i < 16; i++) begin
            tick();
            check({tag, "_hold"}, 32'(RSTN_O), 32'd0);
        end
        tick();
        check({tag, "_rstn_o_up"}, 32'(RSTN_O), 32'd1);
        check({tag, "_pstate_run"}, 32'(PSTATE), 32'd1);
        check({tag, "_busy_low"}, 32'(BUSY), 32'd0);
    endtask

    task automatic enter_gate(input string tag);
        SLP_REQ = 1'b1;
        IDLE    = 1'b1;
        tick();
        check({tag, "_drain"}, 32'(PSTATE), 32'd2);
        tick();
        check({tag, "_gate"}, 32'(PSTATE), 32'd3);
    endtask

    initial begin
        RSTN     = 1'b0;
        SRST_REQ = 1'b0;
        SLP_REQ  = 1'b0;
        IDLE     = 1'b0;
        WAKE     = 1'b0;
        tick(3);
        check_reset_vals("por");

        RSTN = 1'b1;
        expect_hold_release("rel");

        // Full sleep cycle with IDLE arriving two cycles after the request
        SLP_REQ = 1'b1;
        tick();
        check("slp_drain", 32'(PSTATE), 32'd2);
        check("slp_drain_clk", 32'(CLK_EN), 32'd1);
        check("slp_drain_busy", 32'(BUSY), 32'd1);
        tick();
        check("slp_drain_wait", 32'(PSTATE), 32'd2);
        IDLE = 1'b1;
        tick();
        check("slp_gate", 32'(PSTATE), 32'd3);
        check("slp_gate_clk", 32'(CLK_EN), 32'd0);
        check("slp_gate_ack", 32'(SLP_ACK), 32'd1);
        check("slp_gate_rstn", 32'(RSTN_O), 32'd1);
        tick();
        check("slp_gate_hold", 32'(PSTATE), 32'd3);
        WAKE = 1'b1;
        tick();
        WAKE    = 1'b0;
        SLP_REQ = 1'b0;
        IDLE    = 1'b0;
        check("wake_ungate", 32'(PSTATE), 32'd4);
        check("wake_clk", 32'(CLK_EN), 32'd1);
        check("wake_ack", 32'(SLP_ACK), 32'd0);
        tick(3);
        check("settle_3", 32'(PSTATE), 32'd4);
        tick();
        check("settle_run", 32'(PSTATE), 32'd1);

        // Drain abort after five cycles without IDLE
        SLP_REQ = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_drain", 32'(PSTATE), 32'd2);
            check("abort_clk", 32'(CLK_EN), 32'd1);
            check("abort_ack", 32'(SLP_ACK), 32'd0);
        end
        SLP_REQ = 1'b0;
        tick();
        check("abort_run", 32'(PSTATE), 32'd1);
        check("abort_run_clk", 32'(CLK_EN), 32'd1);

        // Soft reset while gated
        enter_gate("sg");
        SLP_REQ  = 1'b0;
        IDLE     = 1'b0;
        SRST_REQ = 1'b1;
        tick();
        SRST_REQ = 1'b0;
        check("sg_pstate", 32'(PSTATE), 32'd0);
        check("sg_clk", 32'(CLK_EN), 32'd1);
        check("sg_rstn_o", 32'(RSTN_O), 32'd0);
        check("sg_ack", 32'(SLP_ACK), 32'd0);
        expect_hold_release("sg");

        // Soft reset and wake in the same GATE cycle: soft reset wins
        enter_gate("sw");
        SLP_REQ  = 1'b0;
        IDLE     = 1'b0;
        SRST_REQ = 1'b1;
        WAKE     = 1'b1;
        tick();
        SRST_REQ = 1'b0;
        WAKE     = 1'b0;
        check("sw_pstate", 32'(PSTATE), 32'd0);
        check("sw_clk", 32'(CLK_EN), 32'd1);

        // Soft reset mid-hold restarts the 16-cycle count
        tick(9);
        check("rs_mid", 32'(PSTATE), 32'd0);
        SRST_REQ = 1'b1;
        tick();
        SRST_REQ = 1'b0;
        check("rs_restart", 32'(PSTATE), 32'd0);
        expect_hold_release("rs");

        // RSTN asserted mid-UNGATE
        enter_gate("ur");
        WAKE = 1'b1;
        tick();
        WAKE    = 1'b0;
        SLP_REQ = 1'b0;
        IDLE    = 1'b0;
        check("ur_ungate", 32'(PSTATE), 32'd4);
        RSTN = 1'b0;
        tick();
        check_reset_vals("ur");
        RSTN = 1'b1;
        expect_hold_release("ur");

`ifdef SCE_PCR_WDT_EN
        // Drain watchdog: 64 DRAIN cycles without IDLE
        SLP_REQ = 1'b1;
        tick();
        check("wdt_drain", 32'(PSTATE), 32'd2);
        for (int i = 1; i < 64; i++) begin
            tick();
            check("wdt_wait", 32'(PSTATE), 32'd2);
            check("wdt_no_err", 32'(SLP_ERR), 32'd0);
        end
        tick();
        SLP_REQ = 1'b0;
        check("wdt_run", 32'(PSTATE), 32'd1);
        check("wdt_err", 32'(SLP_ERR), 32'd1);
        check("wdt_ack", 32'(SLP_ACK), 32'd0);
        tick();
        check("wdt_err_pulse", 32'(SLP_ERR), 32'd0);
`else
        // Without the watchdog, DRAIN waits past the timeout and SLP_ERR stays low
        SLP_REQ = 1'b1;
        tick();
        for (int i = 0; i < 70; i++) begin
            tick();
            check("nowdt_drain", 32'(PSTATE), 32'd2);
            check("nowdt_err", 32'(SLP_ERR), 32'd0);
        end
        SLP_REQ = 1'b0;
        tick();
        check("nowdt_abort", 32'(PSTATE), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
